// File: rtl/tensor_core_pkg.sv
// Shared types, widths and the saturating narrow used by the tensor-core matmul sequencer.
// A register-file image is two 4x4 matrices of signed elements, packed [slot][row][col].
package tensor_core_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + 2;

    typedef logic signed [DATA_WIDTH-1:0]   elem_t;
    typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
    typedef logic signed [ACC_WIDTH-1:0]    acc_t;
    typedef elem_t [3:0][3:0]               matrix_t;
    typedef matrix_t [1:0]                  image_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2
    } mm_state_t;

    typedef struct packed {
        elem_t value;
        logic  clamped;
    } sat_t;

    localparam acc_t SAT_MAX = acc_t'((1 << (DATA_WIDTH - 1)) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(1 << (DATA_WIDTH - 1)));

    function automatic sat_t saturate(input acc_t acc);
        sat_t s;
        s.clamped = 1'b0;
        s.value   = elem_t'(acc);
        if (acc > SAT_MAX) begin
            s.value   = elem_t'(SAT_MAX);
            s.clamped = 1'b1;
        end else if (acc < SAT_MIN) begin
            s.value   = elem_t'(SAT_MIN);
            s.clamped = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/tensor_core_dot4.sv
// Combinational 4-term signed dot product, exact accumulation, then saturated to one element.
module tensor_core_dot4
    import tensor_core_pkg::*;
(
    input  elem_t [3:0] row_a,
    input  elem_t [3:0] col_b,
    output elem_t       result,
    output logic        clamped
);

    acc_t  acc;
    prod_t prod;
    sat_t  sat;

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int k = 0; k < 4; k++) begin
            prod = prod_t'($signed(row_a[k])) * prod_t'($signed(col_b[k]));
            acc  = acc + acc_t'(prod);
        end
        sat = saturate(acc);
    end

    assign result  = sat.value;
    assign clamped = sat.clamped;

endmodule

// File: rtl/tensor_core_matmul_sequencer.sv
// 4x4 signed matmul beside the tensor-core register file: snapshot A/B, one C row per cycle,
// then write the whole image back in a single pulse with C in RESULT_SLOT.
module tensor_core_matmul_sequencer
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH  = tensor_core_pkg::DATA_WIDTH,
    parameter int RESULT_SLOT = 0
) (
    input  logic                      clock_in,
    input  logic                      reset_in,
    input  logic                      start_in,
    input  logic [32*DATA_WIDTH-1:0]  bulk_read_data_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      bulk_write_enable_out,
    output logic [32*DATA_WIDTH-1:0]  bulk_write_data_out,
    output logic                      overflow_out
);

    mm_state_t   state, state_next;
    logic        accept;
    logic [1:0]  row;
    image_t      read_img;
    matrix_t     a_op, b_op, c_res;
    image_t      write_img, write_img_q;
    elem_t [3:0][3:0] b_cols;
    elem_t [3:0] dot_res;
    logic  [3:0] dot_clamp;

    assign read_img = bulk_read_data_in;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) state <= IDLE;
        else           state <= state_next;
    end

    // A start is honoured in IDLE and on the WRITE edge, which lets jobs run back to back.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    accept     = 1'b1;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (row == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                if (start_in) begin
                    accept     = 1'b1;
                    state_next = COMPUTE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_out = (state != IDLE);

    always_comb begin
        b_cols = '0;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
                b_cols[j][k] = b_op[k][j];
    end

    for (genvar j = 0; j < 4; j++) begin : g_col
        tensor_core_dot4 u_dot (
            .row_a   (a_op[row]),
            .col_b   (b_cols[j]),
            .result  (dot_res[j]),
            .clamped (dot_clamp[j])
        );
    end

    always_comb begin
        write_img    = '0;
        write_img[0] = a_op;
        write_img[1] = b_op;
        if (RESULT_SLOT == 0) write_img[0] = c_res;
        else                  write_img[1] = c_res;
    end

    // Operand snapshot and row results carry no reset; only the write pulse exposes them.
    always_ff @(posedge clock_in) begin
        if (accept) begin
            a_op <= read_img[0];
            b_op <= read_img[1];
        end
        if (state == COMPUTE) c_res[row] <= dot_res;
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            row                   <= 2'd0;
            overflow_out          <= 1'b0;
            done_out              <= 1'b0;
            bulk_write_enable_out <= 1'b0;
            write_img_q           <= '0;
        end else begin
            done_out              <= 1'b0;
            bulk_write_enable_out <= 1'b0;
            if (state == COMPUTE) begin
                row <= row + 2'd1;
                if (|dot_clamp) overflow_out <= 1'b1;
            end
            if (state == WRITE) begin
                done_out              <= 1'b1;
                bulk_write_enable_out <= 1'b1;
                write_img_q           <= write_img;
            end
            if (accept) begin
                row          <= 2'd0;
                overflow_out <= 1'b0;
            end
        end
    end

    assign bulk_write_data_out = write_img_q;

endmodule

// File: tb/tb_tensor_core_matmul_sequencer.sv
// Scoreboard bench for the matmul sequencer; two instances cover both result-slot placements.
module tb_tensor_core_matmul_sequencer;

    localparam int DW = 4;
    localparam int W  = 32 * DW;

    logic         clk, rst_n, start;
    logic [W-1:0] rd;
    logic         busy0, done0, we0, ovf0;
    logic         busy1, done1, we1, ovf1;
    logic [W-1:0] wd0, wd1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] img;
        logic         ovf;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [W-1:0] last0;

    tensor_core_matmul_sequencer #(.DATA_WIDTH(DW), .RESULT_SLOT(0)) dut0 (
        .clock_in(clk), .reset_in(rst_n), .start_in(start), .bulk_read_data_in(rd),
        .busy_out(busy0), .done_out(done0), .bulk_write_enable_out(we0),
        .bulk_write_data_out(wd0), .overflow_out(ovf0)
    );

    tensor_core_matmul_sequencer #(.DATA_WIDTH(DW), .RESULT_SLOT(1)) dut1 (
        .clock_in(clk), .reset_in(rst_n), .start_in(start), .bulk_read_data_in(rd),
        .busy_out(busy1), .done_out(done1), .bulk_write_enable_out(we1),
        .bulk_write_data_out(wd1), .overflow_out(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int get_el(input logic [W-1:0] img, input int s, input int r, input int c);
        logic signed [DW-1:0] e;
        e = img[((s*4 + r)*4 + c)*DW +: DW];
        return int'(e);
    endfunction

    function automatic logic [W-1:0] put_el(input logic [W-1:0] img, input int s, input int r,
                                            input int c, input int v);
        logic [W-1:0] o;
        logic [31:0]  vb;
        o  = img;
        vb = v;
        o[((s*4 + r)*4 + c)*DW +: DW] = vb[DW-1:0];
        return o;
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] img, input int slot, output logic ovf);
        logic [W-1:0] o;
        int sum;
        o   = img;
        ovf = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) begin
                sum = 0;
                for (int k = 0; k < 4; k++) sum += get_el(img, 0, r, k) * get_el(img, 1, k, j);
                if (sum > 7)       begin sum = 7;  ovf = 1'b1; end
                else if (sum < -8) begin sum = -8; ovf = 1'b1; end
                o = put_el(o, slot, r, j, sum);
            end
        return o;
    endfunction

    function automatic logic [W-1:0] fill(input int a, input int b);
        logic [W-1:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                o = put_el(o, 0, r, c, a);
                o = put_el(o, 1, r, c, b);
            end
        return o;
    endfunction

    task automatic push_exp(input logic [W-1:0] img);
        exp_t e;
        logic o;
        e.img = model(img, 0, o); e.ovf = o; q0.push_back(e);
        e.img = model(img, 1, o); e.ovf = o; q1.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (we0) begin
            if (q0.size() == 0) check("write0_unexpected", 1, 0);
            else begin
                e = q0.pop_front();
                check("image_slot0", wd0, e.img);
                check("overflow0", ovf0, e.ovf);
                check("done0", done0, 1);
                last0 = e.img;
            end
        end else if (done0) check("done0_stray", done0, 0);
        if (we1) begin
            if (q1.size() == 0) check("write1_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                check("image_slot1", wd1, e.img);
                check("overflow1", ovf1, e.ovf);
            end
        end
    end

    task automatic do_op(input logic [W-1:0] img, input bit scramble);
        int lat;
        @(negedge clk);
        rd    = img;
        start = 1'b1;
        push_exp(img);
        @(posedge clk);
        #1;
        check("busy_after_accept", busy0, 1);
        check("ovf_clear_at_accept", ovf0, 0);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (scramble) rd = {$urandom, $urandom, $urandom, $urandom};
            if (we0) break;
            check("busy_during_op", busy0, 1);
        end
        check("write_latency", lat, 5);
        check("busy_after_write", busy0, 0);
    endtask

    logic [W-1:0] img;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rd    = '0;
        last0 = '0;
        #12;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_we", we0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_data", wd0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // identity times B
        img = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                img = put_el(img, 0, r, c, (r == c) ? 1 : 0);
                img = put_el(img, 1, r, c, r - c);
            end
        do_op(img, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("data_holds", wd0, last0);

        // positive and negative clamps, then overflow clears on the next job
        do_op(fill(7, 7), 1'b0);
        check("ovf_sticky_pos", ovf0, 1);
        do_op(fill(0, 7), 1'b0);
        do_op(fill(-8, 7), 1'b0);
        check("ovf_sticky_neg", ovf0, 1);

        // start held for ten cycles: accepts at T and T+5 only
        @(negedge clk);
        img   = fill(1, 1);
        rd    = img;
        start = 1'b1;
        push_exp(img);
        push_exp(img);
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk);
            #1;
            check("b2b_we", we0, (k == 5 || k == 10));
            check("b2b_busy", busy0, (k < 10));
            if (k == 9) begin
                @(negedge clk);
                start = 1'b0;
            end
        end

        // asynchronous reset in the middle of a job
        @(negedge clk);
        rd    = fill(2, 3);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy0, 0);
        check("midrst_data", wd0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("midrst_no_write", we0 | we1, 0);
        end
        do_op(fill(1, 2), 1'b0);

        // read image churns after accept; snapshot must be used
        for (int t = 0; t < 4; t++) begin
            img = {$urandom, $urandom, $urandom, $urandom};
            do_op(img, 1'b1);
        end

        repeat (4) @(posedge clk);
        #2;
        check("pending_writes", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
